mod_gen_seq: RTL and testbench

- Parametrised, sequential successor to the combinational single-modulus residue generator in the RNS front end.
- Computes R = N mod MOD for an arbitrary WIDTH-bit unsigned operand.
- Method: periodic folding. 2^PERIOD ≡ 1 (mod MOD), so PERIOD-bit chunks are summed with end-around carry, then a compare-subtract correction phase runs.
- One instance per RNS channel, fed from the binary-to-RNS converter input with a valid/ready handshake on both sides.

---
 rtl/mod_gen_seq.sv | 110 +++++++++++
 tb/tb_mod_gen_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_gen_seq.sv
// Sequential residue generator: R = N mod MOD by periodic folding
// with end-around carry followed by a compare-subtract correction.
module mod_gen_seq #(
    parameter int WIDTH  = 16,
    parameter int MOD    = 21,
    parameter int PERIOD = 6,
    localparam int NCHUNK = (WIDTH + PERIOD - 1) / PERIOD,
    localparam int RW     = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] N,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [RW-1:0]    R,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int     SW = NCHUNK * PERIOD;
    localparam int     CW = $clog2(NCHUNK + 1);
    localparam longint P2 = longint'(1) << PERIOD;

    if ((P2 % MOD) != 1 || P2 <= MOD) begin : g_bad_cfg
        $fatal(1, "mod_gen_seq: 2^PERIOD must be > MOD and == 1 mod MOD");
    end

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        CORRECT,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [SW-1:0]     sh, sh_d;
    logic [PERIOD-1:0] acc, acc_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [RW-1:0]     r_q, r_d;
    logic [PERIOD:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            r_q   <= '0;
        end else begin
            state <= state_d;
            sh    <= sh_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            r_q   <= r_d;
        end
    end

    always_comb begin
        state_d = state;
        sh_d    = sh;
        acc_d   = acc;
        cnt_d   = cnt;
        r_d     = r_q;
        sum     = {1'b0, acc} + {1'b0, sh[PERIOD-1:0]};
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = SW'(N);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                // carry out of the chunk sum wraps back in as +1
                if (sum[PERIOD]) begin
                    acc_d = sum[PERIOD-1:0] + PERIOD'(1);
                end else begin
                    acc_d = sum[PERIOD-1:0];
                end
                sh_d  = sh >> PERIOD;
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(NCHUNK - 1)) begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                if (acc >= PERIOD'(MOD)) begin
                    acc_d = acc - PERIOD'(MOD);
                end else begin
                    r_d     = acc[RW-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign R         = r_q;

endmodule

// File: tb/tb_mod_gen_seq.sv
// Bench for mod_gen_seq: directed table, corner sequences, and
// random sweeps over three modulus configurations.
module tb_mod_gen_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int sw_done_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mark_done();
        sw_done_cnt++;
    endtask

    logic        rst_n;
    logic [15:0] n;
    logic        iv;
    logic        ir;
    logic [4:0]  r;
    logic        ov;
    logic        ordy;
    logic        bsy;
    logic        tie;

    mod_gen_seq u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .N        (n),
        .in_valid (iv),
        .in_ready (ir),
        .R        (r),
        .out_valid(ov),
        .out_ready(ordy),
        .busy     (bsy)
    );

    typedef struct {
        logic [15:0] n;
        int          stall;
        logic [4:0]  r;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic run_txn(input logic [15:0] nv, input int stall,
                           input logic [4:0] exp_r, input int exp_lat,
                           input string nm);
        int lat;
        bit hs;
        bit held_ok;
        bit hold_ok;
        n  = nv;
        iv = 1'b1;
        hs = 1'b0;
        for (int w = 0; w < 30 && !hs; w++) begin
            @(negedge clk);
            hs = ir;
            @(posedge clk);
        end
        if (!hs) begin
            chk({nm, "_accept"}, 0, 1);
            $display("FAIL %s: input never accepted", nm);
            $fatal(1);
        end
        #1;
        iv      = 1'b0;
        n       = ~nv;
        lat     = 0;
        held_ok = 1'b1;
        while (!ov && lat < 64) begin
            held_ok &= (ir == 1'b0) && (bsy == 1'b1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_r"}, r, exp_r);
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_busy"}, held_ok && !ir, 1);
        hold_ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
            iv = 1'b1;
            n  = 16'($urandom);
            @(posedge clk);
            #1;
            hold_ok &= ov && (r == exp_r) && !ir;
        end
        if (stall > 0) chk({nm, "_hold"}, hold_ok, 1);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = tie;
        chk({nm, "_release"}, {ov, ir, bsy}, 3'b010);
        iv = 1'b0;
    endtask

    function automatic int cfg_w(int i);
        case (i)
            0: return 16;
            1: return 24;
            default: return 20;
        endcase
    endfunction

    function automatic int cfg_m(int i);
        case (i)
            0: return 21;
            1: return 7;
            default: return 31;
        endcase
    endfunction

    function automatic int cfg_p(int i);
        case (i)
            0: return 6;
            1: return 3;
            default: return 5;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int W   = cfg_w(gi);
        localparam int M   = cfg_m(gi);
        localparam int P   = cfg_p(gi);
        localparam int NC  = (W + P - 1) / P;
        localparam int RWS = $clog2(M);

        logic           rst_n_s = 1'b0;
        logic           iv_s    = 1'b0;
        logic           ordy_s  = 1'b0;
        logic [W-1:0]   n_s     = '0;
        logic [RWS-1:0] r_s;
        logic           ov_s;
        logic           ir_s;
        logic           bsy_s;

        mod_gen_seq #(
            .WIDTH (W),
            .MOD   (M),
            .PERIOD(P)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n_s),
            .N        (n_s),
            .in_valid (iv_s),
            .in_ready (ir_s),
            .R        (r_s),
            .out_valid(ov_s),
            .out_ready(ordy_s),
            .busy     (bsy_s)
        );

        initial begin
            longint nv, er, af, el, full;
            int lat;
            bit hs;
            bit ok;
            full = (longint'(1) << W) - 1;
            repeat (3) @(posedge clk);
            #1 rst_n_s = 1'b1;
            for (int t = 0; t < 120; t++) begin
                if (t == 0) nv = full;
                else if (t == 1) nv = 0;
                else nv = longint'($urandom) & full;
                n_s  = W'(nv);
                iv_s = 1'b1;
                hs   = 1'b0;
                for (int w = 0; w < 30 && !hs; w++) begin
                    @(negedge clk);
                    hs = ir_s;
                    @(posedge clk);
                end
                if (!hs) begin
                    chk($sformatf("sw%0d_accept", gi), 0, 1);
                    break;
                end
                #1;
                iv_s = 1'b0;
                n_s  = ~n_s;
                lat  = 0;
                while (!ov_s && lat < 64) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                // folded sum is N mod (2^P-1) mapped into 1..2^P-1 for N != 0
                er = nv % M;
                af = (nv == 0) ? 0 : ((nv - 1) % ((longint'(1) << P) - 1)) + 1;
                el = NC + af / M + 1;
                chk($sformatf("sw%0d_r_n%0d", gi, nv), r_s, er);
                chk($sformatf("sw%0d_lat_n%0d", gi, nv), lat, el);
                ok = 1'b1;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    ok &= ov_s && (longint'(r_s) == er);
                end
                ordy_s = 1'b1;
                @(posedge clk);
                #1;
                ordy_s = 1'b0;
                chk($sformatf("sw%0d_hold", gi), ok && !ov_s, 1);
            end
            mark_done();
        end
    end

    initial begin
        tbl[0] = '{16'd1000, 0, 5'd13, 6};
        tbl[1] = '{16'd65535, 0, 5'd15, 4};
        tbl[2] = '{16'd1000, 5, 5'd13, 6};
        tbl[3] = '{16'd500, 1, 5'd17, 6};
        tbl[4] = '{16'd4095, 0, 5'd0, 7};
        tbl[5] = '{16'd1, 2, 5'd1, 4};
        tbl[6] = '{16'd64, 0, 5'd1, 4};
        tbl[7] = '{16'd63, 0, 5'd0, 7};
        tbl[8] = '{16'd0, 0, 5'd0, 4};
        tbl[9] = '{16'd20, 0, 5'd20, 4};

        rst_n = 1'b0;
        iv    = 1'b0;
        ordy  = 1'b0;
        tie   = 1'b0;
        n     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {ir, ov, bsy, r}, {3'b100, 5'd0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].n, tbl[i].stall, tbl[i].r, tbl[i].lat,
                    $sformatf("tbl%0d", i));
        end

        n  = 16'd1000;
        iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        chk("rst_mid_busy", bsy, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_state", {ov, ir, bsy, r}, {3'b010, 5'd0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_txn(16'd500, 0, 5'd17, 6, "post_rst");

        tie  = 1'b1;
        ordy = 1'b1;
        run_txn(16'd63, 0, 5'd0, 7, "b2b63");
        run_txn(16'd21, 0, 5'd0, 5, "b2b21");
        run_txn(16'd0, 0, 5'd0, 4, "b2b0");
        tie  = 1'b0;
        ordy = 1'b0;

        for (int c = 0; c < 20000 && sw_done_cnt < 3; c++) @(posedge clk);
        chk("sweeps_done", sw_done_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
